gpi_scan_ctrl: RTL and testbench

- APB master that owns one GPI peripheral (CR at offset 0x0, IDR at offset 0x4) and sequences all accesses to it.
- Writes the input-enable mask to CR, then polls IDR every PERIOD cycles.
- Tracks per-bit changes and raises a sticky, level interrupt to the core.
- Sits between system control logic and the GPI APB slave; the slave registers PREADY one cycle after the access phase starts.

---
 rtl/gpi_scan_ctrl_pkg.sv | 36 +++
 rtl/gpi_scan_ctrl_apb.sv | 78 +++++++
 rtl/gpi_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_gpi_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_scan_ctrl_pkg.sv
// Purpose: shared types and constants for the GPI scan controller and its APB transfer engine.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gpi_pkg;

    // Scan sequencer states. The encodings are fixed so that state dumps stay
    // readable alongside older logs.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CFG_SETUP  = 3'd1,
        ST_CFG_ACCESS = 3'd2,
        ST_WAIT       = 3'd3,
        ST_RD_SETUP   = 3'd4,
        ST_RD_ACCESS  = 3'd5
    } scan_state_e;

    // Phase of the single in-flight APB transfer.
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_e;

    // Register offsets inside the GPI peripheral.
    localparam logic [3:0] GPI_CR_OFS  = 4'h0;
    localparam logic [3:0] GPI_IDR_OFS = 4'h4;

    // Per-bit change flags between two IDR samples. Bits that are not enabled
    // in CR read back as garbage, so they must be masked out here.
    function automatic logic [7:0] gpi_change(input logic [7:0] old_v,
                                              input logic [7:0] new_v,
                                              input logic [7:0] mask);
        return (old_v ^ new_v) & mask;
    endfunction

endpackage

// File: rtl/gpi_scan_ctrl_apb.sv
// Purpose: APB master for exactly one transfer at a time (SETUP, ACCESS, abandon on timeout).
// Latency: start -> SETUP next cycle; done/timeout are combinational in the final ACCESS cycle.
// Backpressure: start is ignored while a transfer is in flight; ACCESS waits up to TIMEOUT cycles for PREADY.
module apb_master_1xfer
    import gpi_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    // request side
    input  logic        start,
    input  logic        write,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    // APB master side
    output logic [3:0]  M_PADDR,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [31:0] M_PWDATA,
    input  logic [31:0] M_PRDATA,
    input  logic        M_PREADY
);

    localparam int CW = $clog2(TIMEOUT + 1);

    apb_phase_e      phase;
    logic [CW-1:0]   acc_cnt;   // ACCESS cycles already spent without PREADY

    // Select/enable are pure decodes of the phase flop, so they drop in the
    // very cycle after the completing ACCESS cycle without any extra stage.
    assign M_PSEL    = (phase != PH_IDLE);
    assign M_PENABLE = (phase == PH_ACCESS);

    // Completion and abandonment are both decided in the last ACCESS cycle.
    assign done    = (phase == PH_ACCESS) && M_PREADY;
    assign timeout = (phase == PH_ACCESS) && !M_PREADY && (acc_cnt == CW'(TIMEOUT - 1));
    assign rdata   = M_PRDATA;

    // Phase sequencing, address/data capture and ACCESS-cycle counting.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            phase    <= PH_IDLE;
            acc_cnt  <= '0;
            M_PADDR  <= '0;
            M_PWRITE <= 1'b0;
            M_PWDATA <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase    <= PH_SETUP;
                        M_PADDR  <= addr;
                        M_PWRITE <= write;
                        M_PWDATA <= wdata;
                    end
                end
                PH_SETUP: begin
                    phase   <= PH_ACCESS;
                    acc_cnt <= '0;
                end
                PH_ACCESS: begin
                    if (done || timeout) begin
                        phase <= PH_IDLE;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gpi_scan_ctrl.sv
// Purpose: owns the GPI peripheral: writes the CR mask, polls IDR every PERIOD cycles, flags per-bit changes.
// Latency: poll starts are PERIOD cycles apart for 3-cycle transfers; pending/irq update on the read's completing edge.
// Backpressure: waits on PREADY up to TIMEOUT ACCESS cycles, then abandons the transfer and sets sticky err.
module gpi_scan_ctrl
    import gpi_pkg::*;
#(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        en,
    input  logic [7:0]  cr_cfg,
    input  logic        irq_clr,
    output logic [3:0]  M_PADDR,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [31:0] M_PWDATA,
    input  logic [31:0] M_PRDATA,
    input  logic        M_PREADY,
    output logic [7:0]  gpi_val,
    output logic [7:0]  pending,
    output logic        irq,
    output logic        err,
    output logic        busy
);

    localparam int WW = $clog2(PERIOD);

    scan_state_e  state;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic [7:0]   cr_shadow;
    logic         primed;

    logic         start;
    logic         xfer_write;
    logic [3:0]   xfer_addr;
    logic         done;
    logic         timeout;
    logic [31:0]  rdata;
    logic [7:0]   rd_byte;
    logic         rd_hi_unused;
    logic         cfg_dirty;
    logic [7:0]   new_change;

    assign wait_nxt     = wait_cnt - 1'b1;
    assign cfg_dirty    = (cr_cfg != cr_shadow);
    assign rd_byte      = rdata[7:0];
    assign rd_hi_unused = ^rdata[31:8];

    // Launch a transfer on the same edge the FSM enters a SETUP state, so the
    // engine's SETUP phase and the FSM's SETUP state always coincide.
    always_comb begin
        start      = 1'b0;
        xfer_write = 1'b0;
        xfer_addr  = GPI_CR_OFS;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    start      = 1'b1;
                    xfer_write = 1'b1;
                end
            end
            ST_WAIT: begin
                if (en) begin
                    if (cfg_dirty) begin
                        start      = 1'b1;
                        xfer_write = 1'b1;
                    end else if (wait_nxt == '0) begin
                        start     = 1'b1;
                        xfer_addr = GPI_IDR_OFS;
                    end
                end
            end
            default: ;
        endcase
    end

    apb_master_1xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_apb (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .start     (start),
        .write     (xfer_write),
        .addr      (xfer_addr),
        .wdata     ({24'b0, cr_cfg}),
        .done      (done),
        .rdata     (rdata),
        .timeout   (timeout),
        .M_PADDR   (M_PADDR),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWRITE  (M_PWRITE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY)
    );

    // Change detection only after the first good sample since enable (priming).
    always_comb begin
        new_change = '0;
        if (state == ST_RD_ACCESS && done && primed) begin
            new_change = gpi_change(gpi_val, rd_byte, cr_shadow);
        end
    end

    // Sticky change flags; a change seen on the clearing edge survives the clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~{8{irq_clr}}) | new_change;
        end
    end

    assign irq  = |pending;
    assign busy = (state == ST_CFG_SETUP) || (state == ST_CFG_ACCESS) ||
                  (state == ST_RD_SETUP)  || (state == ST_RD_ACCESS);

    // Scan sequencer: configure, wait, poll; transfers always run to completion
    // or timeout before en is honoured. cr_shadow only commits on an
    // acknowledged write, so a timed-out write is retried from WAIT.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            cr_shadow <= '0;
            primed    <= 1'b0;
            gpi_val   <= '0;
            err       <= 1'b0;
        end else begin
            if (timeout) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    primed <= 1'b0;
                    if (en) begin
                        state <= ST_CFG_SETUP;
                    end
                end
                ST_CFG_SETUP: state <= ST_CFG_ACCESS;
                ST_CFG_ACCESS: begin
                    if (done || timeout) begin
                        if (done) begin
                            cr_shadow <= M_PWDATA[7:0];
                        end
                        wait_cnt <= WW'(PERIOD - 1);
                        if (en) begin
                            state <= ST_WAIT;
                        end else begin
                            state  <= ST_IDLE;
                            primed <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (!en) begin
                        state  <= ST_IDLE;
                        primed <= 1'b0;
                    end else if (cfg_dirty) begin
                        state <= ST_CFG_SETUP;
                    end else if (wait_nxt == '0) begin
                        state <= ST_RD_SETUP;
                    end
                end
                ST_RD_SETUP: state <= ST_RD_ACCESS;
                ST_RD_ACCESS: begin
                    if (done) begin
                        gpi_val <= rd_byte;
                        primed  <= en;
                    end
                    if (done || timeout) begin
                        // The 3-cycle transfer plus PERIOD-3 WAIT cycles keeps
                        // poll starts exactly PERIOD cycles apart.
                        wait_cnt <= WW'(PERIOD - 3);
                        if (en) begin
                            state <= ST_WAIT;
                        end else begin
                            state  <= ST_IDLE;
                            primed <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpi_scan_ctrl.sv
module tb_gpi_scan_ctrl;

    localparam int PERIOD  = 20;
    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 3 * PERIOD + 40;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  cr_cfg = 8'h00;
    logic        irq_clr = 1'b0;
    logic [3:0]  M_PADDR;
    logic        M_PSEL;
    logic        M_PENABLE;
    logic        M_PWRITE;
    logic [31:0] M_PWDATA;
    logic [31:0] M_PRDATA;
    logic        M_PREADY = 1'b0;
    logic [7:0]  gpi_val;
    logic [7:0]  pending;
    logic        irq;
    logic        err;
    logic        busy;

    gpi_scan_ctrl #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .en        (en),
        .cr_cfg    (cr_cfg),
        .irq_clr   (irq_clr),
        .M_PADDR   (M_PADDR),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWRITE  (M_PWRITE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .gpi_val   (gpi_val),
        .pending   (pending),
        .irq       (irq),
        .err       (err),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    // GPI slave model: PREADY registered one cycle after PSEL&&PENABLE,
    // optionally delayed by 'extra' cycles or stalled forever.
    logic [7:0] pins = 8'h00;
    logic       stall = 1'b0;
    int         extra = 0;
    int         acnt = 0;
    assign M_PRDATA = {24'hDEADBE, pins};

    always @(posedge PCLK) begin
        if (M_PSEL && M_PENABLE && !M_PREADY) begin
            M_PREADY <= !stall && (acnt >= extra);
            acnt     <= acnt + 1;
        end else begin
            M_PREADY <= 1'b0;
            acnt     <= 0;
        end
    end

    // Bus monitor: transfer timing and last write contents.
    int          cyc = 0;
    int          setup_cyc = 0;
    int          acc_run = 0;
    int          rd_done_cnt = 0;
    int          rd_setup_last = 0;
    int          rd_setup_prev = 0;
    int          wr_count = 0;
    int          wr_len = 0;
    int          wr_setup = 0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_addr = 4'h0;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (M_PSEL && !M_PENABLE) begin
            setup_cyc <= cyc;
            acc_run   <= 0;
        end else if (M_PSEL && M_PENABLE) begin
            acc_run <= acc_run + 1;
        end
        if (M_PSEL && M_PENABLE && M_PREADY) begin
            if (M_PWRITE) begin
                wr_count <= wr_count + 1;
                wr_data  <= M_PWDATA;
                wr_addr  <= M_PADDR;
                wr_len   <= cyc - setup_cyc + 1;
                wr_setup <= setup_cyc;
            end else begin
                rd_done_cnt   <= rd_done_cnt + 1;
                rd_setup_prev <= rd_setup_last;
                rd_setup_last <= setup_cyc;
            end
        end
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit cond_hit(input int what);
        case (what)
            0:       return M_PSEL && M_PENABLE && M_PREADY && !M_PWRITE;
            1:       return M_PSEL && M_PENABLE && !M_PWRITE;
            2:       return M_PSEL && !M_PENABLE && !M_PWRITE;
            3:       return !M_PSEL;
            4:       return M_PSEL && M_PENABLE;
            default: return 1'b1;
        endcase
    endfunction

    // Advance negedge by negedge until the bus condition holds (bounded).
    task automatic wait_for(input int what, input string nm);
        int k = 0;
        while (!cond_hit(what) && k < BUDGET) begin
            @(negedge PCLK);
            k++;
        end
        if (!cond_hit(what)) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: condition not seen in %0d cycles, want seen", nm, BUDGET);
        end
    endtask

    // Wait for the next completed IDR read (bounded); returns at a negedge.
    task automatic wait_rd(input string nm);
        int s = rd_done_cnt;
        int k = 0;
        while (rd_done_cnt == s && k < BUDGET) begin
            @(negedge PCLK);
            k++;
        end
        if (rd_done_cnt == s) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: got 0 reads in %0d cycles, want 1", nm, BUDGET);
        end
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        @(negedge PCLK);
        irq_clr = 1'b0;
    endtask

    typedef struct {
        logic       clr;
        logic [7:0] pins;
        logic [7:0] gpi;
        logic [7:0] pend;
        logic       irq;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int wc;
        int c;

        // cr_shadow = 0F, previous sample 00 at the start of the table
        tbl[0] = '{1'b0, 8'h05, 8'h05, 8'h05, 1'b1};
        tbl[1] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h0C, 8'h0C, 8'h09, 1'b1};
        tbl[3] = '{1'b1, 8'h3C, 8'h3C, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h3D, 8'h3D, 8'h01, 1'b1};
        tbl[5] = '{1'b0, 8'h3D, 8'h3D, 8'h01, 1'b1};

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst gpi_val", {24'h0, gpi_val}, 32'h0);
        chk("rst pending", {24'h0, pending}, 32'h0);
        chk("rst irq/err/busy", {29'h0, irq, err, busy}, 32'h0);
        chk("rst bus", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR}, 32'h0);
        chk("rst pwdata", M_PWDATA, 32'h0);

        // Configure then first (priming) read
        en = 1'b1;
        cr_cfg = 8'h0F;
        PRESET = 1'b0;
        wait_rd("prime read");
        chk("cfg wr count", 32'(wr_count), 32'd1);
        chk("cfg wr addr", {28'h0, wr_addr}, 32'h0);
        chk("cfg wr data", wr_data, 32'h0000000F);
        chk("cfg wr cycles", 32'(wr_len), 32'd3);
        chk("first poll offset", 32'(rd_setup_last - wr_setup), 32'(PERIOD + 2));
        chk("prime irq", {31'h0, irq}, 32'h0);
        chk("prime pending", {24'h0, pending}, 32'h0);

        // Table-driven poll vectors
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) pulse_clr();
            pins = tbl[i].pins;
            wait_rd($sformatf("v%0d read", i));
            chk($sformatf("v%0d gpi_val", i), {24'h0, gpi_val}, {24'h0, tbl[i].gpi});
            chk($sformatf("v%0d pending", i), {24'h0, pending}, {24'h0, tbl[i].pend});
            chk($sformatf("v%0d irq", i), {31'h0, irq}, {31'h0, tbl[i].irq});
            chk($sformatf("v%0d poll spacing", i), 32'(rd_setup_last - rd_setup_prev), 32'(PERIOD));
        end

        // Narrow mask: only bit 0 may flag although bits 0 and 2 toggle
        pulse_clr();
        cr_cfg = 8'h01;
        pins = 8'h38;
        wait_rd("mask01 read");
        chk("mask01 wr data", wr_data, 32'h00000001);
        chk("mask01 pending", {24'h0, pending}, 32'h01);

        // Widen mask again; pins steady so pending holds 01
        cr_cfg = 8'h0F;
        wait_rd("mask0F read");
        chk("mask0F wr data", wr_data, 32'h0000000F);
        chk("mask0F pending", {24'h0, pending}, 32'h01);

        // irq_clr coincident with a read that sees bit 2 toggle
        pins = 8'h3C;
        wait_for(0, "read completing");
        irq_clr = 1'b1;
        @(negedge PCLK);
        irq_clr = 1'b0;
        chk("clr+change pending", {24'h0, pending}, 32'h04);
        chk("clr+change irq", {31'h0, irq}, 32'h1);
        pulse_clr();
        chk("lone clr pending", {24'h0, pending}, 32'h0);
        chk("lone clr irq", {31'h0, irq}, 32'h0);

        // Mask change during WAIT: write precedes the next poll
        wc = wr_count;
        cr_cfg = 8'hF0;
        pins = 8'h33;
        wait_rd("maskF0 read");
        chk("maskF0 wr count", 32'(wr_count - wc), 32'd1);
        chk("maskF0 wr data", wr_data, 32'h000000F0);
        chk("maskF0 low toggles", {24'h0, pending}, 32'h0);
        pins = 8'h03;
        wait_rd("maskF0 read2");
        chk("maskF0 high toggles", {24'h0, pending}, 32'h30);

        // Stalled slave: read abandoned after TIMEOUT access cycles
        pulse_clr();
        pins = 8'hF3;
        stall = 1'b1;
        wait_for(2, "stalled read setup");
        wait_for(3, "stalled read abandon");
        chk("tmo err", {31'h0, err}, 32'h1);
        chk("tmo access cycles", 32'(acc_run), 32'(TIMEOUT));
        chk("tmo gpi_val", {24'h0, gpi_val}, 32'h03);
        chk("tmo pending", {24'h0, pending}, 32'h0);
        stall = 1'b0;
        wait_rd("recovery read");
        chk("recov gpi_val", {24'h0, gpi_val}, 32'hF3);
        chk("recov pending", {24'h0, pending}, 32'hF0);
        chk("recov err sticky", {31'h0, err}, 32'h1);

        // en dropped mid-read with a slow slave: read finishes, then idle
        extra = 3;
        wait_for(1, "slow read access");
        en = 1'b0;
        pins = 8'h00;
        wait_rd("slow read");
        chk("endrop gpi_val", {24'h0, gpi_val}, 32'h00);
        chk("endrop busy", {31'h0, busy}, 32'h0);
        chk("endrop psel", {31'h0, M_PSEL}, 32'h0);
        c = 0;
        repeat (2 * PERIOD) begin
            @(negedge PCLK);
            if (M_PSEL) c++;
        end
        chk("idle psel cycles", 32'(c), 32'd0);

        // Asynchronous reset in the middle of a transfer
        extra = 0;
        en = 1'b1;
        wait_for(4, "cfg access");
        PRESET = 1'b1;
        #1;
        chk("arst bus", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR}, 32'h0);
        chk("arst pwdata", M_PWDATA, 32'h0);
        chk("arst outs", {16'h0, gpi_val, pending}, 32'h0);
        chk("arst irq/err/busy", {29'h0, irq, err, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
